// File: rtl/usb_rx_decoder_if.sv
// Line-side inputs and decoded-packet outputs of the USB receive decoder.
// master drives the line, slave is the decoder.
interface usb_rx_decoder_if;
  logic       in_bit;
  logic       in_valid;
  logic       in_eop;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       pkt_start;
  logic       pkt_end;
  logic       err_stuff;
  logic       err_align;

  modport master (
    output in_bit,
    output in_valid,
    output in_eop,
    input  out_byte,
    input  out_valid,
    input  pkt_start,
    input  pkt_end,
    input  err_stuff,
    input  err_align
  );

  modport slave (
    input  in_bit,
    input  in_valid,
    input  in_eop,
    output out_byte,
    output out_valid,
    output pkt_start,
    output pkt_end,
    output err_stuff,
    output err_align
  );
endinterface

// File: rtl/usb_rx_decoder.sv
// USB receive path: NRZI decode, SYNC hunt, bit-unstuffing, byte assembly.
// All outputs are registered; pulses last exactly one cycle.
module usb_rx_decoder (
  input  logic            clk,
  input  logic            rst,
  usb_rx_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    HUNT,
    DATA,
    ERR,
    EOPW
  } state_t;

  state_t     state;
  logic       prev_level;
  logic [2:0] zcnt;
  logic [2:0] ones;
  logic [2:0] bcnt;
  logic [7:0] sreg;

  logic       dbit;
  logic [7:0] nxt;

  assign dbit = (bus.in_bit == prev_level);
  assign nxt  = {dbit, sreg[7:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= HUNT;
      prev_level    <= 1'b1;
      zcnt          <= 3'd0;
      ones          <= 3'd0;
      bcnt          <= 3'd0;
      sreg          <= 8'h00;
      bus.out_byte  <= 8'h00;
      bus.out_valid <= 1'b0;
      bus.pkt_start <= 1'b0;
      bus.pkt_end   <= 1'b0;
      bus.err_stuff <= 1'b0;
      bus.err_align <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      bus.pkt_start <= 1'b0;
      bus.pkt_end   <= 1'b0;
      bus.err_stuff <= 1'b0;
      bus.err_align <= 1'b0;
      unique case (state)
        HUNT: begin
          if (bus.in_eop) begin
            prev_level <= 1'b1;
          end else if (bus.in_valid) begin
            prev_level <= bus.in_bit;
            if (!dbit) begin
              if (zcnt != 3'd7) zcnt <= zcnt + 3'd1;
            end else if (zcnt >= 3'd6) begin
              // the SYNC's closing 1 opens the ones run
              state         <= DATA;
              bus.pkt_start <= 1'b1;
              zcnt          <= 3'd0;
              ones          <= 3'd1;
              bcnt          <= 3'd0;
            end else begin
              zcnt <= 3'd0;
            end
          end
        end
        DATA: begin
          if (bus.in_eop) begin
            bus.pkt_end   <= 1'b1;
            bus.err_align <= (bcnt != 3'd0);
            bcnt          <= 3'd0;
            state         <= EOPW;
          end else if (bus.in_valid) begin
            prev_level <= bus.in_bit;
            if (ones == 3'd6) begin
              if (dbit) begin
                bus.err_stuff <= 1'b1;
                state         <= ERR;
              end else begin
                ones <= 3'd0;
              end
            end else begin
              sreg <= nxt;
              ones <= dbit ? ones + 3'd1 : 3'd0;
              bcnt <= bcnt + 3'd1;
              if (bcnt == 3'd7) begin
                bus.out_byte  <= nxt;
                bus.out_valid <= 1'b1;
              end
            end
          end
        end
        ERR: begin
          if (bus.in_eop) state <= EOPW;
        end
        EOPW: begin
          if (!bus.in_eop) begin
            state      <= HUNT;
            prev_level <= 1'b1;
            zcnt       <= 3'd0;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Bench for usb_rx_decoder: packets are NRZI-encoded with stuffing by the
// bench, which also schedules the output pulses each packet must produce.
module tb_usb_rx_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  usb_rx_decoder_if bus ();

  usb_rx_decoder dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic r;
    logic v;
    logic b;
    logic e;
  } stim_t;

  typedef struct packed {
    logic       st;
    logic       ov;
    logic       pe;
    logic       es;
    logic       ea;
    logic [7:0] ob;
  } resp_t;

  localparam logic [4:0] P_ST = 5'b10000;
  localparam logic [4:0] P_OV = 5'b01000;
  localparam logic [4:0] P_PE = 5'b00100;
  localparam logic [4:0] P_ES = 5'b00010;
  localparam logic [4:0] P_EA = 5'b00001;

  stim_t sq[$];
  resp_t eq[$];
  resp_t oq[$];

  int checks = 0;
  int failures = 0;
  int ones = 0;
  int nbits = 0;
  int gap_max = 2;
  logic lvl = 1'b1;
  logic [7:0] exp_byte = 8'h00;

  // one cycle of stimulus plus the outputs expected right after its edge
  task automatic push(input logic r, input logic v, input logic b,
                      input logic e, input logic [4:0] p,
                      input logic [7:0] nb);
    stim_t s;
    resp_t x;
    if (r) begin
      exp_byte = 8'h00;
      lvl = 1'b1;
    end else if (p[3]) begin
      exp_byte = nb;
    end
    s.r = r;
    s.v = v;
    s.b = b;
    s.e = e;
    x = resp_t'({p, exp_byte});
    sq.push_back(s);
    eq.push_back(x);
  endtask

  task automatic gap();
    int n;
    n = int'($urandom_range(0, gap_max));
    repeat (n) push(1'b0, 1'b0, 1'($urandom), 1'b0, 5'd0, 8'd0);
  endtask

  task automatic send_raw(input logic b, input logic [4:0] p,
                          input logic [7:0] nb);
    gap();
    push(1'b0, 1'b1, b, 1'b0, p, nb);
    lvl = b;
  endtask

  // NRZI: a 1 keeps the line level, a 0 toggles it
  task automatic send_dec(input logic d, input logic [4:0] p,
                          input logic [7:0] nb);
    send_raw(d ? lvl : ~lvl, p, nb);
  endtask

  task automatic start_pkt();
    logic [7:0] syn;
    syn = 8'h2A;
    for (int i = 0; i < 8; i++)
      send_raw(syn[i], (i == 7) ? P_ST : 5'd0, 8'd0);
    ones = 1;
    nbits = 0;
  endtask

  task automatic data_bit(input logic d, input logic [4:0] p,
                          input logic [7:0] nb);
    send_dec(d, p, nb);
    nbits++;
    ones = d ? ones + 1 : 0;
    if (ones == 6) begin
      send_dec(1'b0, 5'd0, 8'd0);
      ones = 0;
    end
  endtask

  task automatic data_byte(input logic [7:0] x);
    for (int i = 0; i < 8; i++)
      data_bit(x[i], (i == 7) ? P_OV : 5'd0, x);
  endtask

  task automatic send_eop(input int n, input bit err, input bit force_v);
    logic [4:0] p;
    p = err ? 5'd0 : (P_PE | (((nbits % 8) != 0) ? P_EA : 5'd0));
    push(1'b0, force_v ? 1'b1 : 1'($urandom), 1'($urandom), 1'b1, p, 8'd0);
    repeat (n - 1)
      push(1'b0, 1'($urandom), 1'($urandom), 1'b1, 5'd0, 8'd0);
    push(1'b0, 1'($urandom), 1'($urandom), 1'b0, 5'd0, 8'd0);
    lvl = 1'b1;
  endtask

  task automatic play();
    oq.delete();
    foreach (sq[i]) begin
      rst = sq[i].r;
      bus.in_valid = sq[i].v;
      bus.in_bit = sq[i].b;
      bus.in_eop = sq[i].e;
      @(posedge clk);
      #1;
      oq.push_back(resp_t'({bus.pkt_start, bus.out_valid, bus.pkt_end,
                            bus.err_stuff, bus.err_align, bus.out_byte}));
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_eop = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) push(1'b1, 1'($urandom), 1'($urandom), 1'($urandom),
                    5'd0, 8'd0);
    repeat (2) push(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 8'd0);
    play();
    foreach (eq[i]) begin
      checks++;
      if (oq[i] !== eq[i]) begin
        failures++;
        $display("FAIL reset cyc=%0d got=%h exp=%h", i, oq[i], eq[i]);
      end
    end
    sq.delete();
    eq.delete();
  endtask

  task automatic test_sync_a5();
    start_pkt();
    data_byte(8'hA5);
    send_eop(3, 1'b0, 1'b0);
    play();
    foreach (eq[i]) begin
      checks++;
      if (oq[i] !== eq[i]) begin
        failures++;
        $display("FAIL sync_a5 cyc=%0d got=%h exp=%h", i, oq[i], eq[i]);
      end
    end
    checks++;
    if (bus.out_byte !== 8'hA5) begin
      failures++;
      $display("FAIL a5_byte got=%h exp=a5", bus.out_byte);
    end
    sq.delete();
    eq.delete();
  endtask

  task automatic test_stuff_ff();
    start_pkt();
    data_byte(8'hFF);
    send_eop(3, 1'b0, 1'b0);
    play();
    foreach (eq[i]) begin
      checks++;
      if (oq[i] !== eq[i]) begin
        failures++;
        $display("FAIL stuff_ff cyc=%0d got=%h exp=%h", i, oq[i], eq[i]);
      end
    end
    sq.delete();
    eq.delete();
  endtask

  task automatic test_stuff_err();
    start_pkt();
    repeat (5) send_dec(1'b1, 5'd0, 8'd0);
    send_dec(1'b1, P_ES, 8'd0);
    send_dec(1'b1, 5'd0, 8'd0);
    send_eop(3, 1'b1, 1'b0);
    start_pkt();
    data_byte(8'h5A);
    send_eop(4, 1'b0, 1'b0);
    play();
    foreach (eq[i]) begin
      checks++;
      if (oq[i] !== eq[i]) begin
        failures++;
        $display("FAIL stuff_err cyc=%0d got=%h exp=%h", i, oq[i], eq[i]);
      end
    end
    sq.delete();
    eq.delete();
  endtask

  task automatic test_align();
    start_pkt();
    repeat (3) data_bit(1'($urandom), 5'd0, 8'd0);
    send_eop(3, 1'b0, 1'b0);
    play();
    foreach (eq[i]) begin
      checks++;
      if (oq[i] !== eq[i]) begin
        failures++;
        $display("FAIL align cyc=%0d got=%h exp=%h", i, oq[i], eq[i]);
      end
    end
    sq.delete();
    eq.delete();
  endtask

  task automatic test_reset_mid();
    start_pkt();
    repeat (5) data_bit(1'($urandom), 5'd0, 8'd0);
    push(1'b1, 1'($urandom), 1'($urandom), 1'b0, 5'd0, 8'd0);
    start_pkt();
    data_byte(8'h3C);
    send_eop(3, 1'b0, 1'b0);
    play();
    foreach (eq[i]) begin
      checks++;
      if (oq[i] !== eq[i]) begin
        failures++;
        $display("FAIL reset_mid cyc=%0d got=%h exp=%h", i, oq[i], eq[i]);
      end
    end
    sq.delete();
    eq.delete();
  endtask

  task automatic test_eop_on_8th();
    start_pkt();
    repeat (7) data_bit(1'($urandom), 5'd0, 8'd0);
    send_eop(3, 1'b0, 1'b1);
    play();
    foreach (eq[i]) begin
      checks++;
      if (oq[i] !== eq[i]) begin
        failures++;
        $display("FAIL eop_8th cyc=%0d got=%h exp=%h", i, oq[i], eq[i]);
      end
    end
    sq.delete();
    eq.delete();
  endtask

  task automatic test_back_to_back();
    gap_max = 0;
    for (int k = 0; k < 4; k++) begin
      start_pkt();
      repeat (2) data_byte(8'($urandom));
      send_eop(3, 1'b0, 1'b0);
    end
    gap_max = 2;
    play();
    foreach (eq[i]) begin
      checks++;
      if (oq[i] !== eq[i]) begin
        failures++;
        $display("FAIL b2b cyc=%0d got=%h exp=%h", i, oq[i], eq[i]);
      end
    end
    sq.delete();
    eq.delete();
  endtask

  task automatic test_random();
    int nby;
    int k;
    for (int pk = 0; pk < 30; pk++) begin
      start_pkt();
      nby = int'($urandom_range(0, 3));
      repeat (nby)
        data_byte(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
      if ($urandom_range(0, 5) == 0) begin
        k = 6 - ones;
        repeat (k) begin
          send_dec(1'b1, 5'd0, 8'd0);
          ones++;
          nbits++;
        end
        send_dec(1'b1, P_ES, 8'd0);
        repeat ($urandom_range(0, 4)) send_dec(1'($urandom), 5'd0, 8'd0);
        send_eop(int'($urandom_range(3, 5)), 1'b1, 1'b0);
      end else begin
        if ($urandom_range(0, 2) == 0)
          repeat ($urandom_range(1, 7)) data_bit(1'($urandom), 5'd0, 8'd0);
        send_eop(int'($urandom_range(3, 5)), 1'b0, 1'b0);
      end
    end
    play();
    foreach (eq[i]) begin
      checks++;
      if (oq[i] !== eq[i]) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, oq[i], eq[i]);
      end
    end
    sq.delete();
    eq.delete();
  endtask

  initial begin
    bus.in_bit = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_eop = 1'b0;
    test_reset();
    test_sync_a5();
    test_stuff_ff();
    test_stuff_err();
    test_align();
    test_reset_mid();
    test_eop_on_8th();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
